// File: rtl/lisp_mem_arbiter.sv
// Boot/run sequencer and core/dbg round-robin arbiter in front of the 1024x16 working RAM.
// Optional MEM_ARB_LOCK_EN lets the core keep exclusive RAM ownership via core_lock.
module lisp_mem_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int BYPASS_BOOT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot_req,
    input  logic                  boot_we,
    input  logic [ADDR_WIDTH-1:0] boot_addr,
    input  logic [DATA_WIDTH-1:0] boot_wdata,
    input  logic                  boot_done,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    input  logic                  core_lock,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic                  boot_gnt,
    output logic                  core_gnt,
    output logic                  dbg_gnt,
    output logic                  core_rvalid,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  in_boot
);

    localparam logic ST_BOOT = 1'b0;
    localparam logic ST_RUN  = 1'b1;
    localparam logic ST_RESET = (BYPASS_BOOT != 0) ? ST_RUN : ST_BOOT;

    logic                  state;
    logic                  prefer_dbg;
    logic                  lock_active;
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

`ifdef MEM_ARB_LOCK_EN
    logic lock_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_flag <= 1'b0;
        end else if (state == ST_RUN) begin
            if (core_gnt && core_lock)
                lock_flag <= 1'b1;
            else if (!core_lock)
                lock_flag <= 1'b0;
        end
    end

    assign lock_active = lock_flag;
`else
    logic unused_core_lock;
    assign unused_core_lock = core_lock;
    assign lock_active      = 1'b0;
`endif

    assign in_boot = (state == ST_BOOT);

    // Grants are forced low while reset is held so every output shows its reset value.
    always_comb begin
        boot_gnt = 1'b0;
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!rst) begin
            if (state == ST_BOOT) begin
                boot_gnt = boot_req && (BYPASS_BOOT == 0);
            end else if (core_req && (!dbg_req || !prefer_dbg || lock_active)) begin
                core_gnt = 1'b1;
            end else if (dbg_req && !lock_active) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_en    = boot_gnt || core_gnt || dbg_gnt;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (boot_gnt) begin
            ram_we    = boot_we;
            ram_addr  = boot_addr;
            ram_wdata = boot_wdata;
        end else if (core_gnt) begin
            ram_we    = core_we;
            ram_addr  = core_addr;
            ram_wdata = core_wdata;
        end else if (dbg_gnt) begin
            ram_addr  = dbg_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_en && ram_we)
            mem[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RESET;
            prefer_dbg  <= 1'b0;
            core_rvalid <= 1'b0;
            dbg_rvalid  <= 1'b0;
            rdata       <= '0;
        end else begin
            if (state == ST_BOOT && boot_done)
                state <= ST_RUN;
            if (core_gnt)
                prefer_dbg <= 1'b1;
            else if (dbg_gnt)
                prefer_dbg <= 1'b0;
            core_rvalid <= core_gnt && !core_we;
            dbg_rvalid  <= dbg_gnt;
            if (ram_en && !ram_we)
                rdata <= mem[ram_addr];
        end
    end

endmodule

// File: tb/tb_lisp_mem_arbiter.sv
// Directed bench for lisp_mem_arbiter: a boot-sequenced instance and a BYPASS_BOOT instance share inputs.
// Expectations for the lock scenario follow MEM_ARB_LOCK_EN.
module tb_lisp_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_req, boot_we, boot_done;
    logic [9:0]  boot_addr;
    logic [15:0] boot_wdata;
    logic        core_req, core_we, core_lock;
    logic [9:0]  core_addr;
    logic [15:0] core_wdata;
    logic        dbg_req;
    logic [9:0]  dbg_addr;

    logic        boot_gnt, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, ram_en, ram_we, in_boot;
    logic [15:0] rdata, ram_wdata;
    logic [9:0]  ram_addr;

    logic        b_boot_gnt, b_core_gnt, b_dbg_gnt, b_core_rvalid, b_dbg_rvalid, b_ram_en, b_ram_we, b_in_boot;
    logic [15:0] b_rdata, b_ram_wdata;
    logic [9:0]  b_ram_addr;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    lisp_mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .BYPASS_BOOT(0)) dut (
        .clk(clk), .rst(rst),
        .boot_req(boot_req), .boot_we(boot_we), .boot_addr(boot_addr), .boot_wdata(boot_wdata),
        .boot_done(boot_done),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_lock(core_lock),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .boot_gnt(boot_gnt), .core_gnt(core_gnt), .dbg_gnt(dbg_gnt),
        .core_rvalid(core_rvalid), .dbg_rvalid(dbg_rvalid), .rdata(rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .in_boot(in_boot)
    );

    lisp_mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .BYPASS_BOOT(1)) dut_byp (
        .clk(clk), .rst(rst),
        .boot_req(boot_req), .boot_we(boot_we), .boot_addr(boot_addr), .boot_wdata(boot_wdata),
        .boot_done(boot_done),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_lock(core_lock),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .boot_gnt(b_boot_gnt), .core_gnt(b_core_gnt), .dbg_gnt(b_dbg_gnt),
        .core_rvalid(b_core_rvalid), .dbg_rvalid(b_dbg_rvalid), .rdata(b_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .in_boot(b_in_boot)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        boot_req = 0; boot_we = 0; boot_addr = '0; boot_wdata = '0; boot_done = 0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_lock = 0;
        dbg_req = 0; dbg_addr = '0;
        step();
        step();
        tests_run++;
        if ({boot_gnt, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, ram_en, ram_we} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                     {boot_gnt, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, ram_en, ram_we});
        end
        tests_run++;
        if ({ram_addr, ram_wdata, rdata} !== 42'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: addr %h wdata %h rdata %h expected all 0", ram_addr, ram_wdata, rdata);
        end
        tests_run++;
        if (in_boot !== 1'b1 || b_in_boot !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_boot: got %b/%b expected 1/0", in_boot, b_in_boot);
        end
        rst = 1'b0;
    endtask

    // Bypass instance runs round robin while the boot instance must keep core/dbg waiting.
    task automatic test_round_robin();
        logic exp_core;
        core_req = 1; core_we = 0; core_addr = 10'h005;
        dbg_req = 1; dbg_addr = 10'h006;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_core = (i % 2 == 0);
            tests_run++;
            if (b_core_gnt !== exp_core || b_dbg_gnt !== !exp_core) begin
                tests_failed++;
                $display("[TB] FAIL rr_gnt[%0d]: core/dbg %b%b expected %b%b", i, b_core_gnt, b_dbg_gnt, exp_core, !exp_core);
            end
            if (i > 0) begin
                tests_run++;
                if (b_core_rvalid !== !exp_core || b_dbg_rvalid !== exp_core) begin
                    tests_failed++;
                    $display("[TB] FAIL rr_rvalid[%0d]: core/dbg %b%b expected %b%b", i, b_core_rvalid, b_dbg_rvalid, !exp_core, exp_core);
                end
            end
            if (!exp_core) begin
                tests_run++;
                if (b_ram_we !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL rr_dbg_we[%0d]: got %b expected 0", i, b_ram_we);
                end
            end
            tests_run++;
            if (core_gnt !== 1'b0 || dbg_gnt !== 1'b0 || in_boot !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL boot_excl[%0d]: core/dbg/in_boot %b%b%b expected 001", i, core_gnt, dbg_gnt, in_boot);
            end
            step();
        end
        core_req = 0; dbg_req = 0;
        #1;
        tests_run++;
        if (b_dbg_rvalid !== 1'b1 || b_core_rvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rr_last_rvalid: core/dbg %b%b expected 01", b_core_rvalid, b_dbg_rvalid);
        end
    endtask

    task automatic test_boot_then_run();
        core_req = 1; core_we = 0; core_addr = 10'h001;
        dbg_req = 1; dbg_addr = 10'h000;
        boot_req = 1; boot_we = 1; boot_addr = 10'h000; boot_wdata = 16'h0001;
        #1;
        tests_run++;
        if (boot_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'h000 || ram_wdata !== 16'h0001) begin
            tests_failed++;
            $display("[TB] FAIL boot_wr0: gnt %b we %b addr %h wdata %h expected 1 1 000 0001", boot_gnt, ram_we, ram_addr, ram_wdata);
        end
        tests_run++;
        if (core_gnt !== 1'b0 || dbg_gnt !== 1'b0 || b_boot_gnt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL boot_excl_wr0: core/dbg/bypass_boot %b%b%b expected 000", core_gnt, dbg_gnt, b_boot_gnt);
        end
        step();
        boot_addr = 10'h001; boot_wdata = 16'h002A; boot_done = 1;
        #1;
        tests_run++;
        if (boot_gnt !== 1'b1 || ram_wdata !== 16'h002A || core_gnt !== 1'b0 || in_boot !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL boot_done_cycle: gnt %b wdata %h core_gnt %b in_boot %b expected 1 002a 0 1", boot_gnt, ram_wdata, core_gnt, in_boot);
        end
        step();
        boot_done = 0; boot_we = 0;
        #1;
        tests_run++;
        if (in_boot !== 1'b0 || boot_gnt !== 1'b0 || core_gnt !== 1'b1 || dbg_gnt !== 1'b0 || ram_addr !== 10'h001) begin
            tests_failed++;
            $display("[TB] FAIL run_first: in_boot %b boot/core/dbg %b%b%b addr %h expected 0 010 001", in_boot, boot_gnt, core_gnt, dbg_gnt, ram_addr);
        end
        step();
        core_req = 0; dbg_req = 0; boot_req = 0;
        #1;
        tests_run++;
        if (core_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || rdata !== 16'h002A) begin
            tests_failed++;
            $display("[TB] FAIL run_read: rvalid core/dbg %b%b rdata %h expected 10 002a", core_rvalid, dbg_rvalid, rdata);
        end
        step();
    endtask

    task automatic test_read_after_write();
        core_req = 1; core_we = 1; core_addr = 10'h3FF; core_wdata = 16'hBEEF;
        #1;
        tests_run++;
        if (core_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'h3FF || ram_wdata !== 16'hBEEF) begin
            tests_failed++;
            $display("[TB] FAIL raw_write: gnt %b we %b addr %h wdata %h expected 1 1 3ff beef", core_gnt, ram_we, ram_addr, ram_wdata);
        end
        step();
        core_we = 0;
        #1;
        tests_run++;
        if (core_gnt !== 1'b1 || core_rvalid !== 1'b0 || ram_we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL raw_read_issue: gnt %b rvalid %b we %b expected 1 0 0", core_gnt, core_rvalid, ram_we);
        end
        step();
        core_req = 0; core_we = 1;
        dbg_req = 1; dbg_addr = 10'h3FF;
        #1;
        tests_run++;
        if (core_rvalid !== 1'b1 || rdata !== 16'hBEEF) begin
            tests_failed++;
            $display("[TB] FAIL raw_data: rvalid %b rdata %h expected 1 beef", core_rvalid, rdata);
        end
        tests_run++;
        if (dbg_gnt !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 10'h3FF) begin
            tests_failed++;
            $display("[TB] FAIL dbg_readonly: gnt %b we %b addr %h expected 1 0 3ff", dbg_gnt, ram_we, ram_addr);
        end
        step();
        dbg_addr = 10'h000;
        #1;
        tests_run++;
        if (dbg_rvalid !== 1'b1 || rdata !== 16'hBEEF || dbg_gnt !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL dbg_b2b: rvalid %b rdata %h gnt %b expected 1 beef 1", dbg_rvalid, rdata, dbg_gnt);
        end
        step();
        dbg_req = 0; core_we = 0;
        #1;
        tests_run++;
        if (dbg_rvalid !== 1'b1 || rdata !== 16'h0001 || core_rvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL dbg_boot_word: dbg_rvalid %b rdata %h core_rvalid %b expected 1 0001 0", dbg_rvalid, rdata, core_rvalid);
        end
        step();
    endtask

    // Core starts favoured; with the lock it keeps the RAM until the cycle after core_lock drops.
    task automatic test_lock();
        logic exp_core;
`ifdef MEM_ARB_LOCK_EN
        logic lock_on = 1'b1;
`else
        logic lock_on = 1'b0;
`endif
        core_req = 1; core_we = 0; core_addr = 10'h001; core_lock = 1;
        dbg_req = 1; dbg_addr = 10'h000;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_core = lock_on || (i % 2 == 0);
            tests_run++;
            if (core_gnt !== exp_core || dbg_gnt !== !exp_core) begin
                tests_failed++;
                $display("[TB] FAIL lock_gnt[%0d]: core/dbg %b%b expected %b%b", i, core_gnt, dbg_gnt, exp_core, !exp_core);
            end
            step();
        end
        core_req = 0; core_lock = 0;
        #1;
        tests_run++;
        if (dbg_gnt !== !lock_on || ram_en !== !lock_on) begin
            tests_failed++;
            $display("[TB] FAIL lock_release: dbg_gnt %b ram_en %b expected %b %b", dbg_gnt, ram_en, !lock_on, !lock_on);
        end
        step();
        #1;
        tests_run++;
        if (dbg_gnt !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL lock_after: dbg_gnt %b expected 1", dbg_gnt);
        end
        step();
        dbg_req = 0;
        step();
    endtask

    task automatic test_reset_mid_read();
        core_req = 1; core_we = 0; core_addr = 10'h010;
        #1;
        tests_run++;
        if (core_gnt !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_gnt: got %b expected 1", core_gnt);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({boot_gnt, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, ram_en, ram_we} !== 7'b0
            || {ram_addr, ram_wdata, rdata} !== 42'b0 || in_boot !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_outputs: ctrl %b addr %h wdata %h rdata %h in_boot %b expected 0 0 0 0 1",
                     {boot_gnt, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, ram_en, ram_we}, ram_addr, ram_wdata, rdata, in_boot);
        end
        step();
        rst = 1'b0; core_req = 0;
        #1;
        tests_run++;
        if (core_rvalid !== 1'b0 || rdata !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL midrst_rvalid: rvalid %b rdata %h expected 0 0000", core_rvalid, rdata);
        end
        step();
        tests_run++;
        if (core_rvalid !== 1'b0 || in_boot !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_after: rvalid %b in_boot %b expected 0 1", core_rvalid, in_boot);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_boot_then_run();
        test_read_after_write();
        test_lock();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lisp_mem_arbiter.md
# lisp_mem_arbiter

Arbiter and sequencer for the core's single-port 1024×16 working RAM. It shares the RAM between three requesters: the boot loader, the eval core and the display/debug reader. It enforces the boot-then-run ordering, and in run mode it round-robins between the core and the display. It sits between the requesters and the RAM inside `core`, directly in front of the synchronous RAM primitive.

## Interface
Parameters:
- `DATA_WIDTH`, 16, RAM word width.
- `ADDR_WIDTH`, 10, RAM address width (1024 words).
- `BYPASS_BOOT`, 0. When 1, reset enters Run directly and the boot port is never granted.

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk` in 1 — system clock.
- `rst` in 1 — async active-high reset.
- `boot_req`, `boot_we` in 1 each; `boot_addr` in ADDR_WIDTH; `boot_wdata` in DATA_WIDTH — boot loader request.
- `boot_done` in 1 — boot loader finished (level or pulse).
- `core_req`, `core_we` in 1 each; `core_addr` in ADDR_WIDTH; `core_wdata` in DATA_WIDTH — eval core request.
- `core_lock` in 1 — keep RAM ownership for the core. Only honoured with `MEM_ARB_LOCK_EN`.
- `dbg_req` in 1; `dbg_addr` in ADDR_WIDTH — display reader, read-only.
- `boot_gnt`, `core_gnt`, `dbg_gnt` out 1 each — request accepted this cycle.
- `core_rvalid`, `dbg_rvalid` out 1 each — read data valid.
- `rdata` out DATA_WIDTH — shared read data. Qualify it with the requester's `*_rvalid`.
- `ram_en`, `ram_we` out 1 each; `ram_addr` out ADDR_WIDTH; `ram_wdata` out DATA_WIDTH — RAM port.
- `in_boot` out 1 — arbiter is in the Boot state.

## Operation
- States:
  - Boot: only the boot requester is serviced. Core and dbg requests wait and are never granted.
  - Run: the boot port is dead and `boot_req` is ignored.
- Reset: the state goes to Boot, or to Run if `BYPASS_BOOT`=1. The round-robin pointer favours the core. The lock flag clears.
- Boot→Run happens at the first rising edge where `boot_done`=1. A boot request in the same cycle is still granted. Run is terminal until reset.
- Selection is combinational within a cycle. At most one grant is asserted per cycle. The RAM outputs mirror the granted requester. `ram_en`=0 when nothing is granted.
- Boot requests may read or write. A boot read produces no rvalid; `rdata` is undefined for boot reads.
- Run arbitration is two-way round robin:
  - If only one of core/dbg requests, that requester is granted.
  - If both request, the one not granted most recently wins.
  - The pointer updates only on a grant.
- dbg is read-only: `ram_we`=0 on every dbg grant.
- A requester holds `req`, `we`, `addr` and `wdata` stable until it sees its `gnt`. It may drop or keep `req` after the grant; keeping it is a new request in the next cycle.
- Read return: for a granted read in cycle N, `*_rvalid`=1 in cycle N+1 for exactly one cycle, with `rdata` = RAM data. Writes produce no rvalid.
- Back-to-back grants are allowed every cycle. Throughput is one access per cycle.

## Timing
- Grant latency: 0 cycles. `gnt` is asserted in the same cycle as `req` when that requester is selected.
- Read latency: 1 cycle from grant to `rvalid` (registered).
- Write: the RAM is written at the rising edge ending the grant cycle. A read of the same address in the next cycle returns the new data.
- Reset values: all `*_gnt`=0, all `*_rvalid`=0, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `rdata`=0. `in_boot`=1, or 0 if `BYPASS_BOOT`=1.
- Reset asserted mid-read clears the pending rvalid. No rvalid is produced after reset for an access granted before it.
- A read granted in the cycle that `boot_done` is sampled still returns its data normally.

## Configuration
- `MEM_ARB_LOCK_EN` defined:
  - A core grant with `core_lock`=1 sets the lock flag.
  - While the flag is set, only the core can be granted and dbg waits.
  - The flag clears at the first edge where `core_lock`=0.
  - Lock is ignored in Boot.
- `MEM_ARB_LOCK_EN` undefined: the `core_lock` port exists but is ignored, and arbitration is pure round robin.

## Test plan
- Boot write then run read: boot writes 0x0001→addr 0x000 and 0x002A→0x001, then pulses `boot_done`. The core reads 0x001 → `core_gnt` in the same cycle, `core_rvalid`=1 next cycle, `rdata`=0x002A. `in_boot` falls after the `boot_done` edge.
- Boot exclusivity: while in Boot, `core_req`=1 and `dbg_req`=1 continuously → no `core_gnt`/`dbg_gnt` until the cycle after `boot_done`.
- Round robin: with `BYPASS_BOOT`=1, core and dbg both hold `req` for 6 cycles → grants alternate core, dbg, core, dbg, core, dbg. Each read gets its rvalid one cycle later.
- Read-after-write: core writes 0xBEEF to 0x3FF in cycle N, then reads 0x3FF in cycle N+1 → `rdata`=0xBEEF with `core_rvalid` in N+2. Any dbg grant shows `ram_we`=0.
- Reset mid-operation: the core reads 0x010 and `rst` is asserted in the grant cycle → `core_rvalid` stays 0, every output returns to its reset value, and `in_boot`=1.
- Lock (`MEM_ARB_LOCK_EN`): the core holds `core_lock`=1 over 4 accesses while dbg requests → dbg is granted only in the cycle after `core_lock` falls. Without the macro, the grants alternate.
